// File: rtl/vme_cmd_responder.sv
// VME command-register responder: decodes one command per transaction against a local 16-bit
// register bank. Optional feature macro: VME_RESP_CNT_EN (top register becomes a completion counter).
module vme_cmd_responder #(
   parameter logic [7:0]  BOARD_ADDR = 8'hA8,
   parameter logic [3:0]  DEV_ID     = 4'h3,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned ACK_DLY    = 2,
   parameter logic [15:0] FW_ID      = 16'hB0D2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] vme_cmd_reg,
   input  logic [31:0] vme_dat_reg_in,
   output logic        vme_cmd_rd,
   output logic        vme_dat_wr,
   output logic [31:0] vme_dat_reg_out
);

   localparam int unsigned NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state;
   logic [31:0]       cmd_q;
   logic [15:0]       dat_q;
   logic [3:0]        wait_cnt;
   logic [31:0]       resp_q;
   logic [15:0]       regs [NREGS];

   logic [ADDR_W-1:0] idx;
   logic              is_rd;
   logic              is_wr;
   logic              cmd_err;
   logic              wr_en;
   logic [15:0]       rd_data;
   logic [31:0]       resp_next;
   logic              unused_bits;

`ifdef VME_RESP_CNT_EN
   logic [15:0]       resp_cnt;
   logic              resp_ok;
`endif

   assign idx   = cmd_q[ADDR_W+1:2];
   assign is_rd = cmd_q[25];
   assign is_wr = cmd_q[24];

   assign cmd_err = (cmd_q[23:16] != BOARD_ADDR) || (cmd_q[15:12] != DEV_ID) || (is_rd == is_wr);

   assign unused_bits = ^{cmd_q[31:26], cmd_q[11:ADDR_W+2], cmd_q[1:0], vme_dat_reg_in[31:16]};

   // Register 0 is the firmware ID and never takes writes; the top register is the counter when enabled.
   always_comb begin
      rd_data = regs[idx];
      wr_en   = !cmd_err && is_wr && (idx != '0);
      if (idx == '0)
         rd_data = FW_ID;
`ifdef VME_RESP_CNT_EN
      if (idx == LAST_IDX) begin
         rd_data = resp_cnt;
         wr_en   = 1'b0;
      end
`endif
   end

   always_comb begin
      resp_next = '0;
      if (cmd_err)
         resp_next = 32'h8000_0000;
      else if (is_wr)
         resp_next = {16'h0000, dat_q};
      else
         resp_next = {16'h0000, rd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         vme_cmd_rd      <= 1'b1;
         vme_dat_wr      <= 1'b0;
         vme_dat_reg_out <= '0;
         cmd_q           <= '0;
         dat_q           <= '0;
         wait_cnt        <= '0;
         resp_q          <= '0;
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
`ifdef VME_RESP_CNT_EN
         resp_cnt        <= '0;
         resp_ok         <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               vme_dat_wr <= 1'b0;
               if (start) begin
                  cmd_q      <= vme_cmd_reg;
                  dat_q      <= vme_dat_reg_in[15:0];
                  vme_cmd_rd <= 1'b0;
                  state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (wr_en)
                  regs[idx] <= dat_q;
               resp_q <= resp_next;
`ifdef VME_RESP_CNT_EN
               resp_ok <= !cmd_err;
`endif
               // The strobe register is set one edge early so it is high exactly in the RESP cycle.
               if (ACK_DLY == 0) begin
                  state           <= S_RESP;
                  vme_dat_wr      <= 1'b1;
                  vme_dat_reg_out <= resp_next;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= 4'(ACK_DLY - 1);
               end
            end
            S_WAIT: begin
               if (wait_cnt == '0) begin
                  state           <= S_RESP;
                  vme_dat_wr      <= 1'b1;
                  vme_dat_reg_out <= resp_q;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               vme_dat_wr <= 1'b0;
               vme_cmd_rd <= 1'b1;
               state      <= S_IDLE;
`ifdef VME_RESP_CNT_EN
               if (resp_ok)
                  resp_cnt <= resp_cnt + 16'd1;
`endif
            end
            default: begin
               state      <= S_IDLE;
               vme_cmd_rd <= 1'b1;
               vme_dat_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule
